// File: rtl/gpac_dac_tx_core_if.sv
// FIFO read port between a first-word-fall-through buffer and the DAC
// transmitter; master is the consumer that pops words.
interface gpac_dac_tx_core_if;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_READ;

  modport master (
    input  FIFO_EMPTY,
    input  FIFO_DATA,
    output FIFO_READ
  );

  modport slave (
    output FIFO_EMPTY,
    output FIFO_DATA,
    input  FIFO_READ
  );
endinterface

// File: rtl/gpac_dac_tx_core.sv
// DAC transmit core: unpacks two samples per FIFO word onto the DAC bus.
// Optional GPAC_DAC_TX_HOLD_EN: hold the last sample on underrun.
module gpac_dac_tx_core #(
  parameter int SAMPLE_BITS = 14,
  parameter int CNT_BITS    = 16,
  parameter logic [SAMPLE_BITS-1:0] IDLE_VALUE = '0
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST_N,
  input  logic                   DAC_CE,
  input  logic                   START,
  input  logic                   STOP,
  input  logic [CNT_BITS-1:0]    SIZE,
  gpac_dac_tx_core_if.master     fifo,
  output logic [SAMPLE_BITS-1:0] DAC_DATA,
  output logic                   DAC_SYNC,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [7:0]             LOST_COUNT
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]             state;
  logic [31:0]            word_q;
  logic                   word_vld;
  logic                   half;
  logic [CNT_BITS-1:0]    cnt;
  logic [CNT_BITS-1:0]    cnt_nx;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   run;
  logic                   emit;
  logic                   underrun;
  logic                   last;
  logic                   pop;
  logic                   unused_bits;

  assign unused_bits = ^{word_q[31:30], word_q[15:14]};

  assign run      = (state == RUN);
  assign cnt_nx   = cnt + CNT_BITS'(1);
  assign emit     = run && DAC_CE && word_vld && !STOP;
  assign underrun = run && DAC_CE && !word_vld && !STOP;
  assign last     = emit && (SIZE != '0) && (cnt_nx == SIZE);
  assign sample   = half ? word_q[0 +: SAMPLE_BITS]
                         : word_q[16 +: SAMPLE_BITS];

  // no pop on the terminating sample so leftover words stay queued
  assign pop = BUS_RST_N && run && !STOP && !last &&
               !fifo.FIFO_EMPTY &&
               (!word_vld || (DAC_CE && half));

  assign fifo.FIFO_READ = pop;
  assign BUSY = run;
  assign DONE = (state == FINISH);

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state      <= IDLE;
      word_q     <= '0;
      word_vld   <= 1'b0;
      half       <= 1'b0;
      cnt        <= '0;
      DAC_DATA   <= IDLE_VALUE;
      DAC_SYNC   <= 1'b0;
      LOST_COUNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          DAC_DATA <= IDLE_VALUE;
          DAC_SYNC <= 1'b0;
          word_vld <= 1'b0;
          if (START) begin
            state      <= RUN;
            cnt        <= '0;
            half       <= 1'b0;
            LOST_COUNT <= '0;
          end
        end
        RUN: begin
          if (STOP) begin
            state <= FINISH;
          end else begin
            if (emit) begin
              DAC_DATA <= sample;
              DAC_SYNC <= (cnt == '0);
              cnt      <= cnt_nx;
              half     <= ~half;
              if (half) word_vld <= 1'b0;
              if (last) state <= FINISH;
            end
            if (underrun) begin
`ifdef GPAC_DAC_TX_HOLD_EN
              DAC_DATA <= DAC_DATA;
`else
              DAC_DATA <= IDLE_VALUE;
`endif
              DAC_SYNC <= 1'b0;
              if (LOST_COUNT != 8'hff)
                LOST_COUNT <= LOST_COUNT + 8'd1;
            end
            if (pop) begin
              word_q   <= fifo.FIFO_DATA;
              word_vld <= 1'b1;
              half     <= 1'b0;
            end
          end
        end
        FINISH: begin
          state    <= IDLE;
          word_vld <= 1'b0;
          DAC_DATA <= IDLE_VALUE;
          DAC_SYNC <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpac_dac_tx_core.sv
// Randomized bench for gpac_dac_tx_core against a queue-based sample
// reference: expected stream is the word list unpacked and truncated.
module tb_gpac_dac_tx_core;

  localparam logic [13:0] IDLE = 14'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dac_ce = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] size = '0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic [13:0] dac_data;
  logic        dac_sync;
  logic        busy;
  logic        done;
  logic [7:0]  lost_count;

  gpac_dac_tx_core_if fif();

  assign fif.FIFO_EMPTY = fifo_empty;
  assign fif.FIFO_DATA  = fifo_data;

  gpac_dac_tx_core #(
    .SAMPLE_BITS(14),
    .CNT_BITS(16),
    .IDLE_VALUE(IDLE)
  ) dut (
    .BUS_CLK(clk),
    .BUS_RST_N(rst_n),
    .DAC_CE(dac_ce),
    .START(start),
    .STOP(stop),
    .SIZE(size),
    .fifo(fif.master),
    .DAC_DATA(dac_data),
    .DAC_SYNC(dac_sync),
    .BUSY(busy),
    .DONE(done),
    .LOST_COUNT(lost_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int done_cnt = 0;
  int emitted = 0;
  int ur_left = 0;
  bit first = 1'b1;

  logic [31:0] fifo_q[$];
  logic [31:0] words[$];
  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic cyc(input logic ce, input logic st, input logic sp);
    logic b;
    logic pr;
    logic [13:0] e;
    dac_ce = ce;
    start  = st;
    stop   = sp;
    b = busy;
    @(negedge clk);
    pr = fif.FIFO_READ;
    @(posedge clk);
    if (pr) begin
      if (fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pops++;
      end else begin
        chk("pop_when_empty", 1, 0);
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
    fifo_data  <= (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    #1;
    if (done) done_cnt++;
    if (ce && b && !sp && rst_n) begin
      if (ur_left > 0) begin
        chk("underrun_data", dac_data, IDLE);
        chk("underrun_sync", dac_sync, 0);
        ur_left--;
      end else if (exp_q.size() == 0) begin
        chk("extra_sample", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample", dac_data, e);
        chk("sync", dac_sync, first);
        first = 1'b0;
        emitted++;
      end
    end
    dac_ce = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
  endtask

  task automatic frame(input int sz, input int per, input int stop_after,
                       input int ur, input bit rnd);
    int limit;
    int pops0;
    int budget;
    int need;
    bit got;
    bit stopped;
    bit pushed;
    logic ce;
    logic st;
    logic sp;
    exp_q.delete();
    first    = 1'b1;
    ur_left  = ur;
    emitted  = 0;
    done_cnt = 0;
    pops0    = pops;
    size     = sz[15:0];
    foreach (words[i]) begin
      exp_q.push_back(words[i][29:16]);
      exp_q.push_back(words[i][13:0]);
    end
    limit = (sz != 0) ? sz : stop_after;
    while (exp_q.size() > limit) void'(exp_q.pop_back());
    pushed = (ur == 0);
    if (pushed) foreach (words[i]) fifo_q.push_back(words[i]);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    got = 0;
    stopped = 0;
    budget = per * (limit + ur + 4) + 40;
    for (int k = 0; k < budget && !got; k++) begin
      ce = (per == 1) ? (k >= 1) : ((k % per) == per - 1);
      st = 1'b0;
      sp = 1'b0;
      if (stop_after > 0 && emitted >= stop_after) begin
        ce = 1'b0;
        sp = !stopped;
        stopped = 1'b1;
      end
      if (rnd && !ce && !sp && busy && $urandom_range(0, 7) == 0)
        st = 1'b1;
      if (!pushed && ur_left == 0) begin
        foreach (words[i]) fifo_q.push_back(words[i]);
        pushed = 1'b1;
      end
      cyc(ce, st, sp);
      if (done) begin
        got = 1'b1;
        chk("busy_at_done", busy, 0);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    cyc(0, 0, 0);
    chk("idle_after_done", dac_data, IDLE);
    chk("busy_after_done", busy, 0);
    cyc(0, 0, 0);
    chk("done_pulses", done_cnt, 1);
    chk("samples_left", exp_q.size(), 0);
    chk("lost_count", lost_count, ur);
    need = (limit + 1) / 2;
    if (stop_after > 0)
      chk("pops_stop", (pops - pops0 >= need) && (pops - pops0 <= need + 1), 1);
    else
      chk("pops", pops - pops0, need);
    fifo_q.delete();
    cyc(0, 0, 0);
  endtask

  initial begin
    int sz;
    repeat (3) cyc(0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("rst_data", dac_data, IDLE);
    chk("rst_sync", dac_sync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", fif.FIFO_READ, 0);
    chk("rst_lost", lost_count, 0);

    words = '{32'h1234_0567, 32'h0ABC_0DEF};
    frame(4, 8, 0, 0, 0);
    frame(3, 8, 0, 0, 0);

    words = '{$urandom()};
    frame(2, 8, 0, 3, 0);

    words.delete();
    for (int i = 0; i < 10; i++) words.push_back($urandom());
    frame(0, 4, 7, 0, 0);

    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom());
    exp_q.delete();
    foreach (words[i]) begin
      exp_q.push_back(words[i][29:16]);
      exp_q.push_back(words[i][13:0]);
    end
    foreach (words[i]) fifo_q.push_back(words[i]);
    first = 1'b1;
    ur_left = 0;
    emitted = 0;
    size = 16'd8;
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int k = 0; k < 60 && emitted < 3; k++)
      cyc((k % 4) == 3, 0, 0);
    rst_n = 1'b0;
    sz = pops;
    cyc(0, 0, 0);
    rst_n = 1'b1;
    chk("midrst_data", dac_data, IDLE);
    chk("midrst_sync", dac_sync, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_read", fif.FIFO_READ, 0);
    chk("midrst_lost", lost_count, 0);
    cyc(0, 0, 0);
    chk("midrst_nopop", pops, sz);
    fifo_q.delete();
    cyc(0, 0, 0);
    frame(4, 5, 0, 0, 0);

    words.delete();
    for (int i = 0; i < 64; i++) words.push_back($urandom());
    frame(128, 1, 0, 0, 0);

    for (int f = 0; f < 8; f++) begin
      sz = $urandom_range(1, 20);
      words.delete();
      for (int i = 0; i < (sz + 1) / 2; i++) words.push_back($urandom());
      frame(sz, $urandom_range(3, 6), 0, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpac_dac_tx_core.md
# gpac_dac_tx_core

Sample-stream transmitter, the transmit-side counterpart of the ADC receive path: it pops 32-bit words from a first-word-fall-through FIFO, unpacks two 14-bit samples per word and presents one sample per clock-enable on a parallel DAC bus. Sits between a `bram_fifo`-style buffer and the DAC pins. Paced by the `CE` output of a `clock_divider`, so it needs only a single clock. Control comes from a bus wrapper as plain ports.

## Interface
Parameters:
- `SAMPLE_BITS`, 14: DAC sample width. Each word packs samples at [29:16] and [13:0].
- `CNT_BITS`, 16: width of the sample counter and `SIZE`.
- `IDLE_VALUE`, 14'h0000: value driven on `DAC_DATA` when no sample is due.

Ports:
- `BUS_CLK` in 1: single clock.
- `BUS_RST_N` in 1: reset, synchronous, active-low.
- `DAC_CE` in 1: sample strobe, one `BUS_CLK` wide.
- `START` in 1: single-cycle pulse that begins a frame.
- `STOP` in 1: single-cycle pulse that aborts or ends a frame.
- `SIZE` in `CNT_BITS`: samples per frame; 0 means continuous until `STOP`.
- `FIFO_EMPTY` in 1: source FIFO empty.
- `FIFO_DATA` in 32: head word, valid while `!FIFO_EMPTY`.
- `FIFO_READ` out 1: pop the head word.
- `DAC_DATA` out `SAMPLE_BITS`: sample output, registered.
- `DAC_SYNC` out 1: high together with the first sample of a frame.
- `BUSY` out 1: frame in progress.
- `DONE` out 1: one-cycle pulse when a frame completes.
- `LOST_COUNT` out 8: underrun counter, saturating at 255 and cleared on `START`.

## Operation
- FSM states:
  - IDLE → `START` → RUN.
  - RUN → sample count reaches `SIZE` (with `SIZE` ≠ 0) → FINISH.
  - RUN → `STOP` → FINISH.
  - FINISH → next cycle → IDLE. FINISH pulses `DONE`.
- Word buffer: `word_q` (32 bits), `word_vld`, and `half` (0 selects [29:16], 1 selects [13:0]).
- In RUN, `FIFO_READ` = `!FIFO_EMPTY && (!word_vld || (DAC_CE && half && word_vld))`. Popping is combinational from the registered state. The popped word loads `word_q` in the same cycle and sets `half`=0.
- On `DAC_CE` in RUN with `word_vld`:
  - drive the selected half onto `DAC_DATA`;
  - toggle `half`;
  - after half 1, clear `word_vld` unless a refill pops in the same cycle;
  - increment `cnt`.
- On `DAC_CE` in RUN without `word_vld` (underrun):
  - drive the underrun value (see Configuration);
  - `cnt` does not advance, so the frame is stretched, not shortened;
  - `LOST_COUNT`++ (saturating).
- `DAC_SYNC` is asserted with the first sample emitted after `START` (`cnt`==0). An underrun delays it.
- If `SIZE` is odd, the second half of the last word is discarded. `word_vld` is cleared in FINISH, and the FIFO is not popped again.
- Bits [31:30] and [15:14] of each word are ignored.
- `cnt` is `CNT_BITS` wide. With `SIZE`=0 it wraps silently and never terminates the frame.
- `START` while in RUN is ignored. `STOP` in IDLE is ignored. `STOP` and `START` in the same IDLE cycle: `START` wins.
- Outside RUN, `DAC_DATA` = `IDLE_VALUE` and `FIFO_READ` = 0.

## Timing
- Reset values: `DAC_DATA`=`IDLE_VALUE`; `DAC_SYNC`, `BUSY`, `DONE`, `FIFO_READ` = 0; `LOST_COUNT`=0; state IDLE; `word_vld`=0.
- Reset mid-frame: returns to IDLE the next cycle. Any buffered word is dropped and the FIFO is not popped.
- `START` at cycle t: `BUSY`=1 from t+1. The first pop can occur at t+1.
- Sample latency: `DAC_DATA` and `DAC_SYNC` update one cycle after the `DAC_CE` cycle that emits them.
- Completion: `cnt`==`SIZE` is reached on the `DAC_CE` cycle of the last sample. `DONE`=1 and `BUSY`=0 follow one cycle later. `DAC_DATA` returns to `IDLE_VALUE` one cycle after that.
- Throughput: with continuous `DAC_CE` (divisor 1), one pop every two cycles sustains the stream with no underrun.

## Configuration
- `GPAC_DAC_TX_HOLD_EN` defined: on underrun, `DAC_DATA` holds the last emitted sample.
- Not defined: on underrun, `DAC_DATA` = `IDLE_VALUE`.
- `LOST_COUNT` behaviour is identical either way.

## Test plan
- FIFO preloaded with 0x1234_0567 and 0x0ABC_0DEF, `SIZE`=4, `DAC_CE` every 8 cycles, `START` → `DAC_DATA` 0x1234, 0x0567, 0x0ABC, 0x0DEF; `DAC_SYNC` only with 0x1234; `DONE` one pulse; exactly 2 pops.
- `SIZE`=3 with 2 words → 3 samples emitted; 0x0DEF is never driven; 2 pops; `LOST_COUNT`=0.
- Empty FIFO for the first 3 strobes, then 1 word, `SIZE`=2 → `LOST_COUNT`=3; 2 samples; `DAC_SYNC` with the first real sample; underrun output per `GPAC_DAC_TX_HOLD_EN` (0x0000 without the macro).
- `SIZE`=0 with 10 words, `STOP` after the 7th sample → `DONE` next cycle; `BUSY` falls; remaining words stay unpopped except at most 1 buffered word.
- `BUS_RST_N` low for 1 cycle mid-frame → every output at its reset value the next cycle; a new `START` restarts with `DAC_SYNC`.
- `DAC_CE` held high continuously, 64 words, `SIZE`=128 → 128 consecutive samples; `LOST_COUNT`=0.
